// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute unit: function codes, mult/div FSM states, sizing.
package alu_exec_pkg;

  localparam int unsigned FUNCT_W    = 5;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned MD_ITER    = 32;
  localparam int unsigned MD_LATENCY = MD_ITER + 2;

  localparam logic [FUNCT_W-1:0] FN_AND  = 5'b00000;
  localparam logic [FUNCT_W-1:0] FN_OR   = 5'b00001;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 5'b00010;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 5'b00011;
  localparam logic [FUNCT_W-1:0] FN_MULT = 5'b00100;
  localparam logic [FUNCT_W-1:0] FN_SLL  = 5'b00101;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 5'b00110;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 5'b00111;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 5'b01000;
  localparam logic [FUNCT_W-1:0] FN_DIV  = 5'b01001;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 5'b01011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [FUNCT_W-1:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring) on magnitudes, with sign fixup.
// fin is asserted for the single FIX cycle; hi/lo are valid alongside it.
module alu_muldiv_seq
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go,
  input  logic             i_op_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_fin_c,
  output logic [WIDTH-1:0] o_hi_c,
  output logic [WIDTH-1:0] o_lo_c
);

  localparam int unsigned DW = 2 * WIDTH;

  md_state_e        r_state, w_state_nxt;
  logic [DW-1:0]    r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_div, w_div_nxt;
  logic             r_neg, w_neg_nxt;
  logic             r_sa, w_sa_nxt;
  logic             r_dz, w_dz_nxt;

  logic [WIDTH-1:0] w_ua, w_ub;
  logic [WIDTH:0]   w_add, w_shift, w_diff;
  logic [DW-1:0]    w_mul_step, w_div_step, w_prod;
  logic [WIDTH-1:0] w_rem, w_q, w_r;
  logic             w_qbit;

  assign w_ua = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_ub = i_b[WIDTH-1] ? -i_b : i_b;

  // Multiply: acc = {partial, multiplier}; add multiplicand when lsb set, shift right.
  assign w_add      = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_add, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left and trial-subtract divisor.
  assign w_shift    = r_acc[DW-1:WIDTH-1];
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem      = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_step = {w_rem, r_acc[WIDTH-2:0], w_qbit};

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_q    = r_acc[WIDTH-1:0];
  assign w_r    = r_acc[DW-1:WIDTH];

  // Sign fixup; divide-by-zero returns all-ones quotient and the dividend as remainder.
  always_comb begin
    o_hi_c = w_prod[DW-1:WIDTH];
    o_lo_c = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_dz) begin
        o_hi_c = r_a;
        o_lo_c = '1;
      end else begin
        o_hi_c = r_sa ? -w_r : w_r;
        o_lo_c = r_neg ? -w_q : w_q;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_opnd_nxt  = r_opnd;
    w_a_nxt     = r_a;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_neg_nxt   = r_neg;
    w_sa_nxt    = r_sa;
    w_dz_nxt    = r_dz;
    o_fin_c     = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_go) begin
          w_state_nxt = MD_RUN;
          w_acc_nxt   = i_op_div ? {WIDTH'(0), w_ua} : {WIDTH'(0), w_ub};
          w_opnd_nxt  = i_op_div ? w_ub : w_ua;
          w_a_nxt     = i_a;
          w_cnt_nxt   = '0;
          w_div_nxt   = i_op_div;
          w_neg_nxt   = i_a[WIDTH-1] ^ i_b[WIDTH-1];
          w_sa_nxt    = i_a[WIDTH-1];
          w_dz_nxt    = i_op_div && (i_b == '0);
        end
      end
      MD_RUN: begin
        w_acc_nxt = r_div ? w_div_step : w_mul_step;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(ITER - 1)) begin
          w_state_nxt = MD_FIX;
        end
      end
      MD_FIX: begin
        o_fin_c     = 1'b1;
        w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg   <= 1'b0;
      r_sa    <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_opnd  <= w_opnd_nxt;
      r_a     <= w_a_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_neg   <= w_neg_nxt;
      r_sa    <= w_sa_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare/shift plus iterative signed mult/div on HI/LO.
// Optional signed-overflow flag on add/sub when ALU_EXEC_OVF_EN is defined.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FUNCT_W-1:0] ALU_funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_zero, r_busy, r_done;

  logic [WIDTH-1:0] w_res, w_sum, w_dif, w_md_hi, w_md_lo;
  logic             w_is_md, w_accept, w_fin, w_lt;

  assign w_accept = start && !r_busy;
  assign w_is_md  = is_muldiv(ALU_funct);
  assign w_sum    = a + b;
  assign w_dif    = a - b;
  assign w_lt     = $signed(a) < $signed(b);

  // Single-cycle datapath; mult/div and undefined codes produce zero here.
  always_comb begin
    w_res = '0;
    case (ALU_funct)
      FN_AND:  w_res = a & b;
      FN_OR:   w_res = a | b;
      FN_ADD:  w_res = w_sum;
      FN_NOR:  w_res = ~(a | b);
      FN_SLL:  w_res = b << shamt;
      FN_SUB:  w_res = w_dif;
      FN_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      FN_SRA:  w_res = WIDTH'($signed(b) >>> shamt);
      FN_XOR:  w_res = a ^ b;
      default: w_res = '0;
    endcase
  end

  alu_muldiv_seq #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_go     (w_accept && w_is_md),
    .i_op_div (ALU_funct == FN_DIV),
    .i_a      (a),
    .i_b      (b),
    .o_fin_c  (w_fin),
    .o_hi_c   (w_md_hi),
    .o_lo_c   (w_md_lo)
  );

  // Handshake and output registers; starts are dropped while a mult/div is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_is_md) begin
          r_busy <= 1'b1;
        end else begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_done   <= 1'b1;
        end
      end else if (w_fin) begin
        r_result <= w_md_lo;
        r_zero   <= (w_md_lo == '0);
        r_hi     <= w_md_hi;
        r_lo     <= w_md_lo;
        r_done   <= 1'b1;
        r_busy   <= 1'b0;
      end
    end
  end

`ifdef ALU_EXEC_OVF_EN
  logic w_ovf, r_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (ALU_funct == FN_ADD) begin
      w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    end else if (ALU_funct == FN_SUB) begin
      w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept && !w_is_md) begin
      r_ovf <= w_ovf;
    end else if (w_fin) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign result = r_result;
  assign zero   = r_zero;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
